ysyx_22050499_ctrl_fsm: RTL and testbench

YSYX_22050499_CTRL_FSM -- requirements
Module: ysyx_22050499_CTRL_FSM

---
 rtl/ysyx_22050499_ctrl_fsm_pkg.sv | 34 +++
 rtl/ysyx_22050499_ctrl_fsm_wait_cnt.sv | 28 ++
 rtl/ysyx_22050499_ctrl_fsm.sv | 100 ++++++++++
 tb/tb_ysyx_22050499_ctrl_fsm.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050499_ctrl_fsm_pkg.sv
// Shared state encoding for the multi-cycle control FSM and anything that decodes its status.
// Also holds the retire/wait state sets and the default memory-wait timeout.
package ysyx_22050499_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    S_IF   = 4'h0,
    S_ID   = 4'h1,
    S_JEXE = 4'h2,
    S_JMEM = 4'h3,
    S_JWB  = 4'h4,
    S_AEXE = 4'h5,
    S_AMEM = 4'h6,
    S_AWB  = 4'h7,
    S_SEXE = 4'h8,
    S_SMEM = 4'h9,
    S_SWB  = 4'hA,
    S_LEXE = 4'hB,
    S_LMEM = 4'hC,
    S_LWB  = 4'hD
  } state_e;

  localparam int MEM_TMO_DEF = 255;

  // States whose exit retires an instruction (pc_we).
  function automatic logic is_retire(input logic [3:0] s);
    return (s == S_JWB) || (s == S_AWB) || (s == S_SWB) || (s == S_LWB);
  endfunction

  // States that wait on an external handshake and are guarded by the timeout.
  function automatic logic is_wait(input logic [3:0] s);
    return (s == S_IF) || (s == S_SMEM) || (s == S_LMEM);
  endfunction

endpackage

// File: rtl/ysyx_22050499_ctrl_fsm_wait_cnt.sv
// Wait-cycle counter: counts while enabled, clears on request, flags the last
// permitted wait cycle so the FSM can give up on the following edge.
module ysyx_22050499_WAIT_CNT
  import ysyx_22050499_ctrl_fsm_pkg::*;
#(
  parameter int MEM_TMO = MEM_TMO_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tmo
);

  localparam int W = $clog2(MEM_TMO + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)   cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en)  cnt_q <= cnt_q + W'(1);
  end

  // cnt_q == MEM_TMO-1 means this is the MEM_TMO-th cycle spent waiting.
  assign tmo = en && (cnt_q == W'(MEM_TMO - 1));

endmodule

// File: rtl/ysyx_22050499_ctrl_fsm.sv
// Multi-cycle core control FSM: fetch, decode dispatch, per-class EXE/MEM/WB
// sequencing, handshake timeouts and a retired-instruction counter.
module ysyx_22050499_ctrl_fsm
  import ysyx_22050499_ctrl_fsm_pkg::*;
#(
  parameter int CNT_W   = 64,
  parameter int MEM_TMO = MEM_TMO_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ifu_valid,
  input  logic             cls_jump,
  input  logic             cls_alu,
  input  logic             cls_store,
  input  logic             cls_load,
  input  logic             is_fence_i,
  input  logic             flush_done,
  input  logic             lsu_done,
  output logic [3:0]       status,
  output logic             ifu_req,
  output logic             lsu_req,
  output logic             lsu_wen,
  output logic             icache_flush,
  output logic             rd_we,
  output logic             pc_we,
  output logic             illegal,
  output logic             mem_err,
  output logic [CNT_W-1:0] instret
);

  logic [3:0]       state_q, state_d;
  logic             fence_q;
  logic             illegal_q, mem_err_q;
  logic [CNT_W-1:0] instret_q;
  logic             wait_done, tmo, tmo_hit, cnt_clr;

  // A handshake arriving on the final wait cycle still wins over the timeout.
  assign wait_done = (state_q == S_IF) ? ifu_valid : lsu_done;
  assign tmo_hit   = tmo && !wait_done;
  assign cnt_clr   = (state_d != state_q) || tmo_hit;

  ysyx_22050499_WAIT_CNT #(.MEM_TMO(MEM_TMO)) u_wait_cnt (
    .clock (clock),
    .reset (reset),
    .en    (is_wait(state_q)),
    .clr   (cnt_clr),
    .tmo   (tmo)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:   if (ifu_valid) state_d = S_ID;
      S_ID: begin
        if      (cls_jump)  state_d = S_JEXE;
        else if (cls_alu)   state_d = S_AEXE;
        else if (cls_store) state_d = S_SEXE;
        else if (cls_load)  state_d = S_LEXE;
        else                state_d = S_IF;
      end
      S_JEXE: state_d = S_JMEM;
      S_JMEM: state_d = S_JWB;
      S_AEXE: state_d = S_AMEM;
      S_AMEM: if (!fence_q || flush_done) state_d = S_AWB;
      S_SEXE: state_d = S_SMEM;
      S_SMEM: if (lsu_done) state_d = S_SWB; else if (tmo_hit) state_d = S_IF;
      S_LEXE: state_d = S_LMEM;
      S_LMEM: if (lsu_done) state_d = S_LWB; else if (tmo_hit) state_d = S_IF;
      default: state_d = S_IF;  // WB states, plus recovery from codes E/F
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IF;
      fence_q   <= 1'b0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= (state_q == S_ID) && !(cls_jump || cls_alu || cls_store || cls_load);
      mem_err_q <= tmo_hit;
      if (state_q == S_ID) fence_q <= is_fence_i;
      if (pc_we) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign status       = state_q;
  assign ifu_req      = (state_q == S_IF);
  assign lsu_req      = (state_q == S_SMEM) || (state_q == S_LMEM);
  assign lsu_wen      = (state_q == S_SMEM);
  assign icache_flush = (state_q == S_AMEM) && fence_q;
  assign rd_we        = (state_q == S_JWB) || (state_q == S_AWB) || (state_q == S_LWB);
  assign pc_we        = is_retire(state_q);
  assign illegal      = illegal_q;
  assign mem_err      = mem_err_q;
  assign instret      = instret_q;

endmodule

// File: tb/tb_ysyx_22050499_ctrl_fsm.sv
// Cycle-vector bench for the control FSM: a table of per-cycle inputs and expected
// outputs is replayed through a scoreboard queue; reset cases are checked by hand.
module tb_ysyx_22050499_ctrl_fsm;

  localparam int CW = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ifu_valid = 1'b0, cls_jump = 1'b0, cls_alu = 1'b0, cls_store = 1'b0, cls_load = 1'b0;
  logic is_fence_i = 1'b0, flush_done = 1'b0, lsu_done = 1'b0;
  logic [3:0] status;
  logic ifu_req, lsu_req, lsu_wen, icache_flush, rd_we, pc_we, illegal, mem_err;
  logic [CW-1:0] instret;

  ysyx_22050499_ctrl_fsm #(.CNT_W(CW), .MEM_TMO(4)) dut (
    .clock(clock), .reset(reset), .ifu_valid(ifu_valid),
    .cls_jump(cls_jump), .cls_alu(cls_alu), .cls_store(cls_store), .cls_load(cls_load),
    .is_fence_i(is_fence_i), .flush_done(flush_done), .lsu_done(lsu_done),
    .status(status), .ifu_req(ifu_req), .lsu_req(lsu_req), .lsu_wen(lsu_wen),
    .icache_flush(icache_flush), .rd_we(rd_we), .pc_we(pc_we),
    .illegal(illegal), .mem_err(mem_err), .instret(instret)
  );

  always #5 clock = ~clock;

  // {ifu_req, lsu_req, lsu_wen, icache_flush, rd_we, pc_we, illegal, mem_err}
  logic [7:0] outs;
  assign outs = {ifu_req, lsu_req, lsu_wen, icache_flush, rd_we, pc_we, illegal, mem_err};

  localparam logic [7:0] O_NONE = 8'b0000_0000, O_IF  = 8'b1000_0000, O_RET = 8'b0000_1100,
                         O_PC   = 8'b0000_0100, O_ST  = 8'b0110_0000, O_LD  = 8'b0100_0000,
                         O_FL   = 8'b0001_0000, O_ILL = 8'b1000_0010, O_ERR = 8'b1000_0001;

  typedef struct {
    logic          ifv;
    logic [3:0]    cls;   // {jump, alu, store, load}
    logic          fen, fd, ld;
    logic [3:0]    st;
    logic [7:0]    outs;
    logic [CW-1:0] ir;
    int            idx;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  logic [CW-1:0] ir_m = '0;
  int tests = 0, fails = 0;

  task automatic add(input logic ifv, input logic [3:0] cls, input logic fen, input logic fd,
                     input logic ld, input logic [3:0] st, input logic [7:0] o);
    vec_t v;
    v.ifv = ifv; v.cls = cls; v.fen = fen; v.fd = fd; v.ld = ld;
    v.st = st; v.outs = o; v.ir = ir_m; v.idx = vecs.size();
    vecs.push_back(v);
    if (o[2]) ir_m = ir_m + 1'b1;
  endtask

  task automatic add_jump(input int waits);
    repeat (waits) add(0, 4'b0000, 0, 0, 0, 4'h0, O_IF);
    add(1, 4'b0000, 0, 0, 0, 4'h0, O_IF);
    add(0, 4'b1000, 0, 0, 0, 4'h1, O_NONE);
    add(0, 4'b0000, 0, 0, 0, 4'h2, O_NONE);
    add(0, 4'b0000, 0, 0, 0, 4'h3, O_NONE);
    add(0, 4'b0000, 0, 0, 0, 4'h4, O_RET);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // Scoreboard consumer: each expectation is checked mid-low-phase of its cycle.
  always @(negedge clock) begin
    #2;
    if (exp_q.size() > 0) begin
      vec_t e;
      e = exp_q.pop_front();
      chk("status",  e.idx, 32'(status),  32'(e.st));
      chk("outputs", e.idx, 32'(outs),    32'(e.outs));
      chk("instret", e.idx, 32'(instret), 32'(e.ir));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Jump with ifu_valid on the third fetch cycle.
    add_jump(2);
    // ALU wins over store/load; flush_done ignored outside a fence wait.
    add(1, 4'b0000, 0, 0, 0, 4'h0, O_IF);
    add(0, 4'b0111, 0, 0, 0, 4'h1, O_NONE);
    add(0, 4'b0000, 0, 1, 0, 4'h5, O_NONE);
    add(0, 4'b0000, 0, 0, 0, 4'h6, O_NONE);
    add(0, 4'b0000, 0, 0, 0, 4'h7, O_RET);
    // Store over load; lsu_done early is ignored, then accepted on entry.
    add(1, 4'b0000, 0, 0, 0, 4'h0, O_IF);
    add(0, 4'b0011, 0, 0, 0, 4'h1, O_NONE);
    add(0, 4'b0000, 0, 0, 1, 4'h8, O_NONE);
    add(0, 4'b0000, 0, 0, 1, 4'h9, O_ST);
    add(0, 4'b0000, 0, 0, 0, 4'hA, O_PC);
    // Load, lsu_done on the third cycle in C.
    add(1, 4'b0000, 0, 0, 0, 4'h0, O_IF);
    add(0, 4'b0001, 0, 0, 0, 4'h1, O_NONE);
    add(0, 4'b0000, 0, 0, 0, 4'hB, O_NONE);
    add(0, 4'b0000, 0, 0, 0, 4'hC, O_LD);
    add(0, 4'b0000, 0, 0, 0, 4'hC, O_LD);
    add(0, 4'b0000, 0, 0, 1, 4'hC, O_LD);
    add(0, 4'b0000, 0, 0, 0, 4'hD, O_RET);
    // fence.i, flush_done on the fifth flush cycle.
    add(1, 4'b0000, 0, 0, 0, 4'h0, O_IF);
    add(0, 4'b0100, 1, 0, 0, 4'h1, O_NONE);
    add(0, 4'b0000, 0, 0, 0, 4'h5, O_NONE);
    for (int k = 0; k < 5; k++) add(0, 4'b0000, 0, (k == 4), 0, 4'h6, O_FL);
    add(0, 4'b0000, 0, 0, 0, 4'h7, O_RET);
    // Illegal: nothing decoded.
    add(1, 4'b0000, 0, 0, 0, 4'h0, O_IF);
    add(0, 4'b0000, 0, 0, 0, 4'h1, O_NONE);
    add(0, 4'b0000, 0, 0, 0, 4'h0, O_ILL);
    // Store timeout after 4 wait cycles, then fetch timeout, then valid on last allowed cycle.
    add(1, 4'b0000, 0, 0, 0, 4'h0, O_IF);
    add(0, 4'b0010, 0, 0, 0, 4'h1, O_NONE);
    add(0, 4'b0000, 0, 0, 0, 4'h8, O_NONE);
    repeat (4) add(0, 4'b0000, 0, 0, 0, 4'h9, O_ST);
    add(0, 4'b0000, 0, 0, 0, 4'h0, O_ERR);
    repeat (3) add(0, 4'b0000, 0, 0, 0, 4'h0, O_IF);
    add(0, 4'b0000, 0, 0, 0, 4'h0, O_ERR);
    add_jump(2);
    // Enough retires to wrap the 4-bit counter.
    repeat (11) add_jump(0);
    // Park in load MEM for the reset test.
    add(1, 4'b0000, 0, 0, 0, 4'h0, O_IF);
    add(0, 4'b0001, 0, 0, 0, 4'h1, O_NONE);
    add(0, 4'b0000, 0, 0, 0, 4'hB, O_NONE);
    add(0, 4'b0000, 0, 0, 0, 4'hC, O_LD);

    // Reset state.
    repeat (2) @(negedge clock);
    chk("rst_status",  -1, 32'(status),  32'h0);
    chk("rst_outputs", -1, 32'(outs),    32'(O_IF));
    chk("rst_instret", -1, 32'(instret), 32'h0);
    @(posedge clock);
    #1 reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clock);
      ifu_valid = vecs[i].ifv;
      {cls_jump, cls_alu, cls_store, cls_load} = vecs[i].cls;
      is_fence_i = vecs[i].fen; flush_done = vecs[i].fd; lsu_done = vecs[i].ld;
      exp_q.push_back(vecs[i]);
    end

    // Reset while waiting in load MEM: immediate return to fetch, no pulses.
    #3;
    reset = 1'b0;
    ifu_valid = 1'b0; {cls_jump, cls_alu, cls_store, cls_load} = 4'b0000;
    is_fence_i = 1'b0; flush_done = 1'b0; lsu_done = 1'b0;
    #1;
    chk("midrst_status",  -1, 32'(status),  32'h0);
    chk("midrst_outputs", -1, 32'(outs),    32'(O_IF));
    chk("midrst_instret", -1, 32'(instret), 32'h0);
    @(posedge clock);
    #1;
    chk("rst_hold_outputs", -1, 32'(outs), 32'(O_IF));
    @(negedge clock);
    reset = 1'b1;
    ifu_valid = 1'b1;
    @(posedge clock);
    #1;
    chk("resume_status",  -1, 32'(status), 32'h1);
    chk("resume_outputs", -1, 32'(outs),   32'(O_NONE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
